pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/halt controller: RUN/DRAIN/HALTED FSM driving pipeline register enables.
// Optional stall counter is built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [3:0]  ex_rd,
  input  logic        br_taken,
  input  logic        id_halt,
  input  logic        dmem_busy,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        idex_wen,
  output logic        exmem_wen,
  output logic        memwb_wen,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e     state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       load_use;

  always_comb begin
    load_use = ex_memread && (ex_rd != 4'd0) &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  end

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_wen     = 1'b0;
    ifid_wen   = 1'b0;
    idex_wen   = 1'b0;
    exmem_wen  = 1'b0;
    memwb_wen  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    if (rst) begin
      // Reset looks like RUN with both front stages flushed
      pc_wen     = 1'b1;
      ifid_wen   = 1'b1;
      idex_wen   = 1'b1;
      exmem_wen  = 1'b1;
      memwb_wen  = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (dmem_busy) begin
            // full freeze: every enable already low
          end else if (load_use) begin
            idex_wen   = 1'b1;
            idex_flush = 1'b1;
            exmem_wen  = 1'b1;
            memwb_wen  = 1'b1;
          end else if (id_halt) begin
            idex_wen  = 1'b1;
            exmem_wen = 1'b1;
            memwb_wen = 1'b1;
            state_d   = StDrain;
            drain_d   = 2'd3;
          end else begin
            pc_wen     = 1'b1;
            ifid_wen   = 1'b1;
            idex_wen   = 1'b1;
            exmem_wen  = 1'b1;
            memwb_wen  = 1'b1;
            ifid_flush = br_taken;
          end
        end
        StDrain: begin
          if (!dmem_busy) begin
            idex_wen   = 1'b1;
            idex_flush = 1'b1;
            exmem_wen  = 1'b1;
            memwb_wen  = 1'b1;
            drain_d    = drain_q - 2'd1;
            if (drain_q == 2'd1) begin
              state_d = StHalted;
            end
          end
        end
        StHalted: begin
          halted = 1'b1;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_wen && (state_q != StHalted) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst, ex_memread, id_uses_rs, id_uses_rt, br_taken, id_halt, dmem_busy;
  logic [3:0]  id_rs, id_rt, ex_rd;
  logic        pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, halted;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .br_taken   (br_taken),
    .id_halt    (id_halt),
    .dmem_busy  (dmem_busy),
    .pc_wen     (pc_wen),
    .ifid_wen   (ifid_wen),
    .idex_wen   (idex_wen),
    .exmem_wen  (exmem_wen),
    .memwb_wen  (memwb_wen),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halted}
  typedef struct {
    logic [7:0]  outs;
    logic [7:0]  mask;
    logic [15:0] cnt;
    bit          cnt_known;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_issued = 0;

  // Reference model: mode 0 = run, 1 = drain, 2 = halted
  int m_mode = 0;
  int m_left = 0;
  int m_stalls = 0;
  bit m_known = 0;

  task automatic model_push();
    exp_t e;
    bit   lu;
    lu = ex_memread && ex_rd != 0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    e.mask = 8'hFF;
    if (rst)                          e.outs = 8'b11111_11_0;
    else if (m_mode == 2)             e.outs = 8'b00000_00_1;
    else if (m_mode == 1) begin
      if (dmem_busy) begin
        e.outs = 8'b00000_00_0;
        e.mask = 8'b11111_00_1;
      end else                        e.outs = 8'b00111_01_0;
    end
    else if (dmem_busy)               e.outs = 8'b00000_00_0;
    else if (lu)                      e.outs = 8'b00111_01_0;
    else if (id_halt)                 e.outs = 8'b00111_00_0;
    else if (br_taken)                e.outs = 8'b11111_10_0;
    else                              e.outs = 8'b11111_00_0;
`ifdef PIPE_CTRL_PERF_CNT_EN
    e.cnt = 16'(m_stalls);
    e.cnt_known = m_known;
`else
    e.cnt = 16'h0000;
    e.cnt_known = 1'b1;
`endif
    e.id = n_issued;
    n_issued++;
    sb.push_back(e);
    if (rst) begin
      m_mode = 0; m_left = 0; m_stalls = 0; m_known = 1;
    end else begin
      if (!e.outs[7] && m_mode != 2 && m_stalls < 65535) m_stalls++;
      if (m_mode == 0 && !dmem_busy && !lu && id_halt) begin
        m_mode = 1; m_left = 3;
      end else if (m_mode == 1 && !dmem_busy) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic mr, input logic [3:0] rd, input logic [3:0] rs,
                     input logic [3:0] rt, input logic urs, input logic urt, input logic br,
                     input logic hlt, input logic busy);
    @(posedge clk);
    #1;
    rst = r; ex_memread = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt; br_taken = br; id_halt = hlt; dmem_busy = busy;
    model_push();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic busy_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e = sb.pop_front();
      got = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, halted};
      n_checks++;
      if ((got & e.mask) !== (e.outs & e.mask)) begin
        n_errors++;
        $display("FAIL ctrl_outs cycle %0d: got %b required %b (mask %b)", e.id, got, e.outs,
                 e.mask);
      end
      if (e.cnt_known) begin
        n_checks++;
        if (stall_cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL stall_cnt cycle %0d: got %h required %h", e.id, stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ex_memread = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; br_taken = 0; id_halt = 0; dmem_busy = 0;

    do_reset();
    do_reset();
    idle(2);
    // load-use on rs, then load has moved on
    cyc(0, 1, 3, 3, 0, 1, 0, 0, 0, 0);
    idle(1);
    // taken branch alone, then with concurrent load-use on rt
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 5, 0, 5, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // ex_rd == 0 never stalls
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    // four-cycle freeze from reset
    do_reset();
    busy_n(4);
    idle(2);
    // halt with branch: drain three cycles then halted
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(5);
    // drain stretched by two busy cycles
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    busy_n(2);
    idle(4);
    // reset from halted and from mid-drain
    do_reset();
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    do_reset();
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 2), $urandom_range(0, 1), 4'($urandom_range(0, 3)),
          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 1),
          $urandom_range(0, 1), ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 20));
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    // drive the counter into saturation
    do_reset();
    busy_n(65540);
    idle(2);
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
